kstep_spi_target: RTL
=====================

Name: kstep_spi_target

Overview:
- SPI target front-end sitting directly upstream of the kstep register file and stepper core inside tt_um_koconnor_kstep.
- Oversamples raw SPI pins (cs, mosi, sclk) in the system clock domain, decodes command/address/data frames, and issues single-cycle register write/read strobes.
- Serialises read data back on miso.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
- ADDR_W, 7, register address width (command byte = 1 R/W bit + ADDR_W bits).
- DATA_W, 32, register data word width.
- SYNC_STAGES, 2, flops in each pin synchroniser (minimum 2).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- spi_cs  in  1  chip select, active low (uio_in[0]).
- spi_mosi  in  1  target data in (uio_in[1]).
- spi_sclk  in  1  SPI clock (uio_in[3]).
- spi_miso  out  1  target data out (uio_out[2]).
- spi_miso_oe  out  1  high while cs is (synchronised) low.
- reg_addr  out  ADDR_W  register address for current access.
- reg_wdata  out  DATA_W  write data, valid when reg_wr=1.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_W  read data; must be valid the cycle after reg_rd.
- busy  out  1  high from cs-fall detection until return to IDLE.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high (rst).
- Reset values:
  - spi_miso=0, spi_miso_oe=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0.
  - FSM=IDLE, all counters and shift registers 0.
  - Synchronisers reset to cs=1, sclk=0, mosi=0.
- Synchronisation and edge detection:
  - All three pins pass through SYNC_STAGES flops.
  - sclk rise/fall are detected from the last synchronised stage and its registered copy.
  - clk must be >= 8x sclk frequency.
- Frame format:
  - Command byte: bit7 = 1 write / 0 read; bits 6:0 = address.
  - Then DATA_W-bit words.
  - Burst: further words after the first access address+1, wrapping 127 -> 0 (modulo 2^ADDR_W).
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on synchronised cs low; bit counter cleared.
  - CMD:
    - Shift mosi into the command register on each sclk rise.
    - After 8th rise: latch address into reg_addr and go to DATA.
    - If read: pulse reg_rd on the cycle following the 8th rise.
  - DATA:
    - Sample mosi on sclk rise; counter counts 0..DATA_W-1.
    - Write, on DATA_W-th rise: reg_wdata = shifted word; reg_wr pulses the next cycle with the current reg_addr. reg_addr then increments in the cycle after the reg_wr pulse; counter reset.
    - Read, on DATA_W-th rise: increment reg_addr and pulse reg_rd for the next word.
  - Any state -> IDLE within 1 cycle of synchronised cs high.
    - A partial word is discarded: no reg_wr.
    - A reg_rd already issued is harmless.
- MISO:
  - tx shift register loads reg_rdata the cycle after reg_rd.
  - spi_miso = tx[DATA_W-1].
  - Shift left on each sclk fall that follows a DATA-phase rise (the fall after the command byte's 8th rise does not shift).
  - spi_miso = 0 during CMD and for write frames.
- Latency: reg_wr/reg_rd assert exactly SYNC_STAGES+2 clk cycles after the raw sclk rise of the final bit.
- Simultaneous cs rise with a final sclk rise: cs wins; no strobe.
- sclk edges while cs is high are ignored.
- Reset mid-frame: immediate return to reset values; no strobe; next frame needs a fresh cs fall.

Decomposition:
- Shared package kstep_pkg holds:
  - CMD_WRITE_BIT (7), ADDR_W/DATA_W defaults.
  - FSM state enum spi_state_t {IDLE, CMD, DATA}.
- Sub-module kstep_sync_edge: N-stage synchroniser with rise/fall pulse outputs, instantiated for sclk, plus plain sync for cs/mosi.

Test Plan:
- Write frame 0x85 + 0xDEADBEEF -> single reg_wr with reg_addr=0x05, reg_wdata=0xDEADBEEF; no reg_rd.
- Read frame 0x05 with reg_rdata=0x12345678 -> one reg_rd at addr 0x05; miso bits decode to 0x12345678; spi_miso_oe high only while cs low.
- Write burst 0xFF + 0x00000001 + 0x00000002 -> reg_wr at addr 0x7F data 1, then addr 0x00 data 2 (wrap).
- cs raised after 20 data bits of write 0x83 -> no reg_wr; busy low; next full frame to 0x03 works normally.
- rst asserted mid-read burst -> all outputs 0 within the reset edge; no further strobes until new cs fall.
- sclk toggling with cs high -> no strobes, FSM stays IDLE, miso 0.

Source files
------------

// File: rtl/kstep_pkg.sv
// kstep shared definitions.
// Frame layout constants and SPI target FSM states.
package kstep_pkg;

  localparam int CMD_WRITE_BIT = 7;
  localparam int ADDR_W_DEF    = 7;
  localparam int DATA_W_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } spi_state_t;

endpackage

// File: rtl/kstep_spi_target_if.sv
// SPI pins and register-bus bundle.
// slave = SPI target side, master = host/register-file side.
interface kstep_spi_target_if
  import kstep_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              spi_cs;
  logic              spi_mosi;
  logic              spi_sclk;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy;

  modport slave (
    input  spi_cs, spi_mosi, spi_sclk,
    input  reg_rdata,
    output spi_miso, spi_miso_oe,
    output reg_addr, reg_wdata,
    output reg_wr, reg_rd, busy
  );

  modport master (
    output spi_cs, spi_mosi, spi_sclk,
    output reg_rdata,
    input  spi_miso, spi_miso_oe,
    input  reg_addr, reg_wdata,
    input  reg_wr, reg_rd, busy
  );

endinterface

// File: rtl/kstep_sync_edge.sv
// N-flop pin synchroniser.
// i_edge also gets rise/fall pulses; i_lvl is level only.
module kstep_sync_edge #(
  parameter int            N        = 2,
  parameter int            W        = 2,
  parameter logic [W-1:0]  LVL_RST  = '0,
  parameter logic          EDGE_RST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_edge,
  input  logic [W-1:0] i_lvl,
  output logic [W-1:0] o_lvl,
  output logic         o_rise,
  output logic         o_fall
);

  logic [W:0] r_sync [N];
  logic       r_prev;
  logic       w_edge;

  // shift pins through the chain; keep a copy of the edge pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        r_sync[i] <= {EDGE_RST, LVL_RST};
      r_prev <= EDGE_RST;
    end else begin
      r_sync[0] <= {i_edge, i_lvl};
      for (int i = 1; i < N; i++)
        r_sync[i] <= r_sync[i-1];
      r_prev <= w_edge;
    end
  end

  assign w_edge = r_sync[N-1][W];
  assign o_lvl  = r_sync[N-1][W-1:0];
  assign o_rise = w_edge & ~r_prev;
  assign o_fall = ~w_edge & r_prev;

endmodule

// File: rtl/kstep_spi_target.sv
// kstep SPI target: oversampled mode-0 frame decoder
// issuing register read/write strobes and serialising miso.
module kstep_spi_target
  import kstep_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  kstep_spi_target_if.slave bus
);

  localparam int CW = $clog2(DATA_W);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WRITE_BIT);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  spi_state_t r_state, w_next;

  logic [1:0] w_lvl;
  logic       w_cs, w_mosi, w_rise, w_fall;

  logic [CW-1:0]            r_cnt;
  logic [CMD_WRITE_BIT-1:0] r_cmd;
  logic [DATA_W-2:0]        r_shift;
  logic [DATA_W-1:0]        r_tx, r_wdata;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_is_wr, r_wr_pend, r_rd_pend;
  logic                     r_wr, r_rd, r_tx_load;
  logic                     r_shift_arm, r_arm;
  logic [SW-1:0]            r_settle;

  logic [CMD_WRITE_BIT:0] w_cmd_byte;
  logic [DATA_W-1:0]      w_word;

  kstep_sync_edge #(
    .N        (SYNC_STAGES),
    .W        (2),
    .LVL_RST  (2'b10),
    .EDGE_RST (1'b0)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_edge (bus.spi_sclk),
    .i_lvl  ({bus.spi_cs, bus.spi_mosi}),
    .o_lvl  (w_lvl),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_cs       = w_lvl[1];
  assign w_mosi     = w_lvl[0];
  assign w_cmd_byte = {r_cmd, w_mosi};
  assign w_word     = {r_shift, w_mosi};

  // arm only once the synchronised cs has been seen high
  // after reset, so a frame needs a fresh cs fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= '0;
      r_arm    <= 1'b0;
    end else if (r_settle != SW'(SYNC_STAGES)) begin
      r_settle <= r_settle + SW'(1);
    end else if (w_cs) begin
      r_arm <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next-state: cs high always wins over any sclk edge
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (r_arm && !w_cs) w_next = CMD;
      CMD: begin
        if (w_cs)
          w_next = IDLE;
        else if (w_rise && r_cnt == CMD_LAST)
          w_next = DATA;
      end
      DATA: if (w_cs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // shifting, strobes, address and miso datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_wdata     <= '0;
      r_addr      <= '0;
      r_is_wr     <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_tx_load   <= 1'b0;
      r_shift_arm <= 1'b0;
    end else begin
      r_wr      <= r_wr_pend;
      r_rd      <= r_rd_pend;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_tx_load <= r_rd;
      if (r_wr) r_addr <= r_addr + ADDR_W'(1);
      if (r_tx_load) r_tx <= bus.reg_rdata;
      unique case (r_state)
        IDLE: begin
          r_cnt       <= '0;
          r_shift_arm <= 1'b0;
          r_tx        <= '0;
        end
        CMD: begin
          if (!w_cs && w_rise) begin
            r_cmd <= w_cmd_byte[CMD_WRITE_BIT-1:0];
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CMD_LAST) begin
              r_cnt     <= '0;
              r_addr    <= w_cmd_byte[ADDR_W-1:0];
              r_is_wr   <= w_cmd_byte[CMD_WRITE_BIT];
              r_rd_pend <= !w_cmd_byte[CMD_WRITE_BIT];
            end
          end
        end
        DATA: begin
          if (!w_cs && w_rise) begin
            r_shift     <= w_word[DATA_W-2:0];
            r_cnt       <= r_cnt + CW'(1);
            r_shift_arm <= 1'b1;
            if (r_cnt == DATA_LAST) begin
              // last bit: fresh tx word loads, its fall must not shift
              r_cnt       <= '0;
              r_shift_arm <= 1'b0;
              if (r_is_wr) begin
                r_wdata   <= w_word;
                r_wr_pend <= 1'b1;
              end else begin
                r_addr    <= r_addr + ADDR_W'(1);
                r_rd_pend <= 1'b1;
              end
            end
          end
          if (!w_cs && w_fall && r_shift_arm) begin
            r_tx        <= r_tx << 1;
            r_shift_arm <= 1'b0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.spi_miso    = (r_state == DATA) && !r_is_wr
                         && r_tx[DATA_W-1];
  assign bus.spi_miso_oe = !w_cs;
  assign bus.busy        = (r_state != IDLE);
  assign bus.reg_addr    = r_addr;
  assign bus.reg_wdata   = r_wdata;
  assign bus.reg_wr      = r_wr;
  assign bus.reg_rd      = r_rd;

endmodule
